// File: rtl/fa_pkg.sv
// Shared constants and types for the registered full adder.
package fa_pkg;

  localparam int CNT_W_DEF = 8;

  typedef struct packed {
    logic carry;
    logic sum;
  } fa_res_t;

endpackage

// File: rtl/half_adder.sv
// Half adder: sum = x ^ y, carry = x & y.
module half_adder (
  input  logic x,
  input  logic y,
  output logic sum,
  output logic carry
);

  assign sum   = x ^ y;
  assign carry = x & y;

endmodule

// File: rtl/full_adder_always.sv
// Full adder with combinational and registered outputs; optional saturating stats
// counters compiled in with FULL_ADDER_ALWAYS_STATS_EN. Synchronous active-low Reset.
module full_adder_always
  import fa_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic             a0,
  input  logic             a1,
  input  logic             c0,
  output logic             s,
  output logic             c1,
  output logic             s_q,
  output logic             c1_q,
  output logic             vld_q,
  output logic [CNT_W-1:0] carry_cnt,
  output logic [CNT_W-1:0] op_cnt
);

  logic    ha0_sum;
  logic    ha0_carry;
  logic    ha1_sum;
  logic    ha1_carry;
  fa_res_t res_d;

  half_adder u_ha0 (
    .x     (a0),
    .y     (a1),
    .sum   (ha0_sum),
    .carry (ha0_carry)
  );

  half_adder u_ha1 (
    .x     (ha0_sum),
    .y     (c0),
    .sum   (ha1_sum),
    .carry (ha1_carry)
  );

  assign res_d.sum   = ha1_sum;
  assign res_d.carry = ha0_carry | ha1_carry;

  assign s  = res_d.sum;
  assign c1 = res_d.carry;

  always_ff @(posedge clk) begin
    if (!Reset) begin
      s_q   <= 1'b0;
      c1_q  <= 1'b0;
      vld_q <= 1'b0;
    end else begin
      s_q   <= res_d.sum;
      c1_q  <= res_d.carry;
      vld_q <= 1'b1;
    end
  end

`ifdef FULL_ADDER_ALWAYS_STATS_EN
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] op_cnt_q;
  logic [CNT_W-1:0] carry_cnt_q;
  logic [CNT_W-1:0] op_cnt_d;
  logic [CNT_W-1:0] carry_cnt_d;

  // Counters hold at all-ones instead of wrapping.
  always_comb begin
    op_cnt_d    = op_cnt_q;
    carry_cnt_d = carry_cnt_q;
    if (!(&op_cnt_q)) begin
      op_cnt_d = op_cnt_q + CNT_ONE;
    end
    if (res_d.carry && !(&carry_cnt_q)) begin
      carry_cnt_d = carry_cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!Reset) begin
      op_cnt_q    <= '0;
      carry_cnt_q <= '0;
    end else begin
      op_cnt_q    <= op_cnt_d;
      carry_cnt_q <= carry_cnt_d;
    end
  end

  assign op_cnt    = op_cnt_q;
  assign carry_cnt = carry_cnt_q;
`else
  assign op_cnt    = '0;
  assign carry_cnt = '0;
`endif

endmodule

// File: tb/tb_full_adder_always.sv
// Directed, table-driven bench for full_adder_always; a CNT_W=2 instance covers saturation.
module tb_full_adder_always;

`ifdef FULL_ADDER_ALWAYS_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       Reset;
  logic       a0, a1, c0;
  logic       s, c1, s_q, c1_q, vld_q;
  logic [7:0] carry_cnt, op_cnt;
  logic       s2, c12, s_q2, c1_q2, vld_q2;
  logic [1:0] carry_cnt2, op_cnt2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  full_adder_always dut (
    .clk(clk), .Reset(Reset), .a0(a0), .a1(a1), .c0(c0),
    .s(s), .c1(c1), .s_q(s_q), .c1_q(c1_q), .vld_q(vld_q),
    .carry_cnt(carry_cnt), .op_cnt(op_cnt)
  );

  full_adder_always #(.CNT_W(2)) dut2 (
    .clk(clk), .Reset(Reset), .a0(a0), .a1(a1), .c0(c0),
    .s(s2), .c1(c12), .s_q(s_q2), .c1_q(c1_q2), .vld_q(vld_q2),
    .carry_cnt(carry_cnt2), .op_cnt(op_cnt2)
  );

  typedef struct {
    logic a0;
    logic a1;
    logic c0;
    logic c1;
    logic s;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int cexp(input int n);
    return STATS ? n : 0;
  endfunction

  initial begin
    // {a0,a1,c0} from cnt = {c0,a1,a0}; expected {c1,s}: 00,01,01,10,01,10,10,11
    vecs[0] = '{0, 0, 0, 0, 0};
    vecs[1] = '{1, 0, 0, 0, 1};
    vecs[2] = '{0, 1, 0, 0, 1};
    vecs[3] = '{1, 1, 0, 1, 0};
    vecs[4] = '{0, 0, 1, 0, 1};
    vecs[5] = '{1, 0, 1, 1, 0};
    vecs[6] = '{0, 1, 1, 1, 0};
    vecs[7] = '{1, 1, 1, 1, 1};

    // Reset held two edges, then released
    Reset = 1'b0; a0 = 1'b0; a1 = 1'b0; c0 = 1'b0;
    tick();
    chk("rst_vld_e1", vld_q, 0);
    tick();
    chk("rst_vld_e2", vld_q, 0);
    chk("rst_s_q", s_q, 0);
    chk("rst_c1_q", c1_q, 0);
    chk("rst_op_cnt", op_cnt, 0);
    chk("rst_carry_cnt", carry_cnt, 0);
    Reset = 1'b1;
    tick();
    chk("rel_vld", vld_q, 1);
    chk("rel_op_cnt", op_cnt, cexp(1));
    chk("rel_carry_cnt", carry_cnt, 0);

    // Fresh reset, then all 8 combinations once
    Reset = 1'b0;
    tick();
    Reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      {c0, a1, a0} = 3'(i);
      #1;
      chk($sformatf("comb_s_%0d", i), s, vecs[i].s);
      chk($sformatf("comb_c1_%0d", i), c1, vecs[i].c1);
      chk($sformatf("vec_a0_%0d", i), a0, vecs[i].a0);
      tick();
      chk($sformatf("reg_s_q_%0d", i), s_q, vecs[i].s);
      chk($sformatf("reg_c1_q_%0d", i), c1_q, vecs[i].c1);
    end
    chk("sweep_op_cnt", op_cnt, cexp(8));
    chk("sweep_carry_cnt", carry_cnt, cexp(4));
    chk("sweep_op_cnt2_sat", op_cnt2, cexp(3));
    chk("sweep_carry_cnt2_sat", carry_cnt2, cexp(3));

    // Consecutive carry-generating patterns, 1-cycle latency
    a0 = 1'b1; a1 = 1'b1; c0 = 1'b0;
    tick();
    chk("seq1_s_q", s_q, 0);
    chk("seq1_c1_q", c1_q, 1);
    c0 = 1'b1;
    tick();
    chk("seq2_s_q", s_q, 1);
    chk("seq2_c1_q", c1_q, 1);

    // Saturation: inputs 1,1,1 for 6 edges after reset
    Reset = 1'b0;
    tick();
    Reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (i == 2) begin
        chk("sat3_op_cnt2", op_cnt2, cexp(3));
        chk("sat3_carry_cnt2", carry_cnt2, cexp(3));
      end
    end
    chk("sat6_op_cnt2", op_cnt2, cexp(3));
    chk("sat6_carry_cnt2", carry_cnt2, cexp(3));
    chk("sat6_op_cnt", op_cnt, cexp(6));
    chk("sat6_carry_cnt", carry_cnt, cexp(6));
    chk("sat6_vld2", vld_q2, 1);

    // Mid-run reset with nonzero counters; combinational path keeps following inputs
    a0 = 1'b1; a1 = 1'b0; c0 = 1'b1;
    Reset = 1'b0;
    tick();
    chk("mid_s_q", s_q, 0);
    chk("mid_c1_q", c1_q, 0);
    chk("mid_vld", vld_q, 0);
    chk("mid_op_cnt", op_cnt, 0);
    chk("mid_carry_cnt", carry_cnt, 0);
    chk("mid_op_cnt2", op_cnt2, 0);
    chk("mid_s", s, 0);
    chk("mid_c1", c1, 1);
    c0 = 1'b0;
    #1;
    chk("mid_s_b", s, 1);
    chk("mid_c1_b", c1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/full_adder_always.md
FULL_ADDER_ALWAYS -- requirements
Module: full_adder_always

Interface
REQ-001 The block SHALL have parameter CNT_W, default 8, giving the width of the statistics counters.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port Reset, input, 1 bit: one clock; reset is synchronous and active-low.
REQ-004 The block SHALL have port a0, input, 1 bit: addend bit A.
REQ-005 The block SHALL have port a1, input, 1 bit: addend bit B.
REQ-006 The block SHALL have port c0, input, 1 bit: carry-in.
REQ-007 The block SHALL have port s, output, 1 bit: combinational sum.
REQ-008 The block SHALL have port c1, output, 1 bit: combinational carry-out.
REQ-009 The block SHALL have port s_q, output, 1 bit: registered sum.
REQ-010 The block SHALL have port c1_q, output, 1 bit: registered carry-out.
REQ-011 The block SHALL have port vld_q, output, 1 bit: registered outputs valid.
REQ-012 The block SHALL have port carry_cnt, output, CNT_W bits: count of cycles with carry-out set.
REQ-013 The block SHALL have port op_cnt, output, CNT_W bits: count of cycles since reset release.

Function
REQ-014 s SHALL equal a0 XOR a1 XOR c0, purely combinational with zero latency and no dependence on clk or Reset.
REQ-015 c1 SHALL equal (a0 AND a1) OR (a0 AND c0) OR (a1 AND c0), purely combinational with zero latency.
REQ-016 {c1,s} SHALL equal the 2-bit arithmetic sum a0+a1+c0 for all 8 input combinations; X/Z inputs are not required to be handled.
REQ-017 s_q and c1_q SHALL capture s and c1 at each rising clk edge while Reset=1, giving 1-cycle latency.
REQ-018 vld_q SHALL go to 1 at the first rising edge with Reset=1 and stay at 1 until reset.
REQ-019 op_cnt SHALL increment by 1 on each rising edge with Reset=1, saturating at all-ones with no wrap.
REQ-020 carry_cnt SHALL increment by 1 on each rising edge with Reset=1 and c1=1, saturating at all-ones with no wrap.
REQ-021 When a counter is saturated and the increment condition holds, the counter SHALL hold its value.

Reset
REQ-022 Reset=0 sampled at a rising clk edge SHALL force s_q=0, c1_q=0, vld_q=0, carry_cnt=0 and op_cnt=0 on that edge.
REQ-023 Reset SHALL take priority over all other updates, including when asserted mid-run.
REQ-024 Reset SHALL have no effect on the combinational outputs s and c1.

Configuration
REQ-025 Macro FULL_ADDER_ALWAYS_STATS_EN SHALL compile in the carry_cnt and op_cnt counter logic.
REQ-026 Without FULL_ADDER_ALWAYS_STATS_EN, ports carry_cnt and op_cnt SHALL remain present and be tied to constant 0, and no counter flops shall be inferred.
REQ-027 All other behaviour SHALL be identical with and without the macro.

Structure
REQ-028 Shared package fa_pkg SHALL hold the CNT_W default constant and a typedef for the 2-bit {carry,sum} result.
REQ-029 The block SHALL be built from one sub-module, half_adder (inputs x,y; outputs sum=x^y, carry=x&y).
REQ-030 The full adder SHALL be composed of two half_adder instances plus an OR of their carries.

Verification
REQ-031 Drive a 3-bit free-running counter cnt onto {c0,a1,a0} through values 0..7; the bench SHALL check {c1,s} = 00,01,01,10,01,10,10,11 respectively, with zero latency.
REQ-032 Apply a0=1, a1=1, c0=0, then a0=1, a1=1, c0=1 on consecutive edges; the bench SHALL check s_q/c1_q = 0/1 one cycle later, then 1/1.
REQ-033 Hold Reset=0 for 2 edges, then release it; the bench SHALL check vld_q=0 during reset and vld_q=1 from the first edge after release, with op_cnt=1 after that edge.
REQ-034 With the macro defined, run all 8 combinations once after reset; the bench SHALL check op_cnt=8 and carry_cnt=4.
REQ-035 With CNT_W=2 and inputs held at 1,1,1 for 6 edges, the bench SHALL check carry_cnt and op_cnt saturate at 3.
REQ-036 Assert Reset=0 mid-run with nonzero counters; the bench SHALL check all registered outputs are 0 after that edge while s/c1 still follow the inputs.
